// File: rtl/vga_pkg.sv
// Shared video timing constants and helpers for the timing generator.
package vga_pkg;

    // 640x480@60 (25.175 MHz pixel rate), both syncs active low
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam bit VGA_HS_POL   = 1'b0;
    localparam bit VGA_VS_POL   = 1'b0;

    // 800x600@60 (40 MHz pixel rate), both syncs active high
    localparam int SVGA_H_ACTIVE = 800;
    localparam int SVGA_H_FP     = 40;
    localparam int SVGA_H_SYNC   = 128;
    localparam int SVGA_H_BP     = 88;
    localparam int SVGA_V_ACTIVE = 600;
    localparam int SVGA_V_FP     = 1;
    localparam int SVGA_V_SYNC   = 4;
    localparam int SVGA_V_BP     = 23;
    localparam bit SVGA_HS_POL   = 1'b1;
    localparam bit SVGA_VS_POL   = 1'b1;

    // Full period of one axis: active, front porch, sync, back porch
    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // First count of the sync region on one axis
    function automatic int axis_sync_start(input int active, input int fp);
        return active + fp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: a wrapping position counter plus decode of the position
// it is about to enter, so the parent can register outputs with zero skew.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = VGA_H_ACTIVE,
    parameter int FP     = VGA_H_FP,
    parameter int SYNC   = VGA_H_SYNC,
    parameter int BP     = VGA_H_BP,
    parameter bit POL    = 1'b0,
    parameter int W      = 10
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    output logic [W-1:0] o_count,
    output logic         o_wrap,
    output logic [W-1:0] o_next_count,
    output logic         o_next_active,
    output logic         o_next_sync,
    output logic         o_next_at_zero,
    output logic         o_next_at_active_end
);

    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
    localparam int SYNC_START = axis_sync_start(ACTIVE, FP);

    localparam logic [W-1:0] L_LAST       = W'(TOTAL - 1);
    localparam logic [W-1:0] L_ACTIVE     = W'(ACTIVE);
    // One extra bit so a zero back porch (sync end == TOTAL) still compares right
    localparam logic [W:0]   L_SYNC_START = (W+1)'(SYNC_START);
    localparam logic [W:0]   L_SYNC_END   = (W+1)'(SYNC_START + SYNC);

    logic [W-1:0] r_cnt;
    logic [W-1:0] w_next;
    logic         w_at_last;
    logic         w_in_sync;

    assign w_at_last = (r_cnt == L_LAST);

    // Next position: advance only when enabled, wrapping exactly at TOTAL-1
    always_comb begin
        w_next = r_cnt;
        if (i_en) begin
            w_next = w_at_last ? '0 : r_cnt + W'(1);
        end
    end

    // Reset parks on the last position so the first enable enters zero
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= L_LAST;
        end else begin
            r_cnt <= w_next;
        end
    end

    assign w_in_sync = ({1'b0, w_next} >= L_SYNC_START) && ({1'b0, w_next} < L_SYNC_END);

    assign o_count              = r_cnt;
    assign o_wrap               = w_at_last;
    assign o_next_count         = w_next;
    assign o_next_active        = (w_next < L_ACTIVE);
    assign o_next_sync          = w_in_sync ? POL : ~POL;
    assign o_next_at_zero       = (w_next == '0);
    assign o_next_at_active_end = (w_next == L_ACTIVE);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised video timing generator: syncs, data enable, pixel
// coordinates and line/frame/vblank strobes, all registered together.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit HS_POL   = VGA_HS_POL,
    parameter bit VS_POL   = VGA_VS_POL,
    parameter int X_W      = 10,
    parameter int Y_W      = 10
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_pix_stb,
    output logic           o_hs,
    output logic           o_vs,
    output logic           o_de,
    output logic [X_W-1:0] o_x,
    output logic [Y_W-1:0] o_y,
    output logic           o_line_start,
    output logic           o_frame_start,
    output logic           o_vblank_start
);

    localparam logic [X_W-1:0] L_X_SAT = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0] L_Y_SAT = Y_W'(V_ACTIVE - 1);

    logic           w_h_wrap;
    logic [X_W-1:0] w_h_next;
    logic           w_h_active;
    logic           w_h_sync;
    logic           w_h_zero;
    logic           w_v_en;
    logic [Y_W-1:0] w_v_next;
    logic           w_v_active;
    logic           w_v_sync;
    logic           w_v_zero;
    logic           w_v_active_end;

    // Vertical steps once per line, on the strobe that wraps the horizontal
    assign w_v_en = i_pix_stb & w_h_wrap;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (HS_POL),
        .W      (X_W)
    ) u_h_axis (
        .i_clk                (i_clk),
        .i_rst                (i_rst),
        .i_en                 (i_pix_stb),
        .o_count              (),
        .o_wrap               (w_h_wrap),
        .o_next_count         (w_h_next),
        .o_next_active        (w_h_active),
        .o_next_sync          (w_h_sync),
        .o_next_at_zero       (w_h_zero),
        .o_next_at_active_end ()
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (VS_POL),
        .W      (Y_W)
    ) u_v_axis (
        .i_clk                (i_clk),
        .i_rst                (i_rst),
        .i_en                 (w_v_en),
        .o_count              (),
        .o_wrap               (),
        .o_next_count         (w_v_next),
        .o_next_active        (w_v_active),
        .o_next_sync          (w_v_sync),
        .o_next_at_zero       (w_v_zero),
        .o_next_at_active_end (w_v_active_end)
    );

    // Register every output from the position being entered; hold between strobes
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_hs           <= ~HS_POL;
            o_vs           <= ~VS_POL;
            o_de           <= 1'b0;
            o_x            <= '0;
            o_y            <= '0;
            o_line_start   <= 1'b0;
            o_frame_start  <= 1'b0;
            o_vblank_start <= 1'b0;
        end else if (i_pix_stb) begin
            o_hs           <= w_h_sync;
            o_vs           <= w_v_sync;
            o_de           <= w_h_active & w_v_active;
            o_x            <= w_h_active ? w_h_next : L_X_SAT;
            o_y            <= w_v_active ? w_v_next : L_Y_SAT;
            o_line_start   <= w_h_zero;
            o_frame_start  <= w_h_zero & w_v_zero;
            o_vblank_start <= w_h_zero & w_v_active_end;
        end else begin
            o_line_start   <= 1'b0;
            o_frame_start  <= 1'b0;
            o_vblank_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a tiny 8x6
// instance share one clock. A behavioural model queues the expected output
// vector for every driven cycle; directed counters add timing-level checks.
module tb_vga_timing_gen;

    typedef struct packed {
        int ha; int hf; int hs; int hb;
        int va; int vf; int vs; int vb;
        bit hp; bit vp;
    } tim_t;

    localparam tim_t T0 = '{ha: 640, hf: 16, hs: 96, hb: 48,
                            va: 480, vf: 10, vs: 2, vb: 33, hp: 1'b0, vp: 1'b0};
    localparam tim_t T1 = '{ha: 4, hf: 1, hs: 2, hb: 1,
                            va: 3, vf: 1, vs: 1, vb: 1, hp: 1'b1, vp: 1'b1};

    // ---------------- clock / reset ----------------
    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, stb0, rst1, stb1;

    logic       o_hs0, o_vs0, o_de0, o_ls0, o_fs0, o_vbs0;
    logic [9:0] o_x0, o_y0;
    logic       o_hs1, o_vs1, o_de1, o_ls1, o_fs1, o_vbs1;
    logic [2:0] o_x1, o_y1;

    vga_timing_gen u_dut0 (
        .i_clk          (clk),
        .i_rst          (rst0),
        .i_pix_stb      (stb0),
        .o_hs           (o_hs0),
        .o_vs           (o_vs0),
        .o_de           (o_de0),
        .o_x            (o_x0),
        .o_y            (o_y0),
        .o_line_start   (o_ls0),
        .o_frame_start  (o_fs0),
        .o_vblank_start (o_vbs0)
    );

    vga_timing_gen #(
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .HS_POL   (1'b1), .VS_POL (1'b1),
        .X_W      (3), .Y_W (3)
    ) u_dut1 (
        .i_clk          (clk),
        .i_rst          (rst1),
        .i_pix_stb      (stb1),
        .o_hs           (o_hs1),
        .o_vs           (o_vs1),
        .o_de           (o_de1),
        .o_x            (o_x1),
        .o_y            (o_y1),
        .o_line_start   (o_ls1),
        .o_frame_start  (o_fs1),
        .o_vblank_start (o_vbs1)
    );

    // Observed vector layout: {hs, vs, de, line, frame, vblank, x[15:0], y[15:0]}
    logic [37:0] obs0, obs1;
    assign obs0 = {o_hs0, o_vs0, o_de0, o_ls0, o_fs0, o_vbs0, 16'(o_x0), 16'(o_y0)};
    assign obs1 = {o_hs1, o_vs1, o_de1, o_ls1, o_fs1, o_vbs1, 16'(o_x1), 16'(o_y1)};

    // ---------------- scoreboard ----------------
    logic [37:0] exp_q0[$];
    logic [37:0] exp_q1[$];
    int          m_h[2];
    int          m_v[2];
    logic [37:0] m_prev[2];
    int          tests;
    int          fails;

    // Behavioural position model; pushes the expected vector for one cycle
    task automatic model(input int k, input bit rst, input bit stb);
        tim_t        t;
        int          htot, vtot, h, v, x, y;
        logic        hs, vs, de;
        logic [37:0] e;
        t    = (k == 0) ? T0 : T1;
        htot = t.ha + t.hf + t.hs + t.hb;
        vtot = t.va + t.vf + t.vs + t.vb;
        if (rst) begin
            m_h[k] = htot - 1;
            m_v[k] = vtot - 1;
            e = {~t.hp, ~t.vp, 4'b0000, 32'd0};
        end else if (stb) begin
            m_h[k] = m_h[k] + 1;
            if (m_h[k] == htot) begin
                m_h[k] = 0;
                m_v[k] = m_v[k] + 1;
                if (m_v[k] == vtot) m_v[k] = 0;
            end
            h  = m_h[k];
            v  = m_v[k];
            hs = (h >= t.ha + t.hf && h < t.ha + t.hf + t.hs) ? t.hp : ~t.hp;
            vs = (v >= t.va + t.vf && v < t.va + t.vf + t.vs) ? t.vp : ~t.vp;
            de = (h < t.ha) && (v < t.va);
            x  = (h < t.ha) ? h : t.ha - 1;
            y  = (v < t.va) ? v : t.va - 1;
            e  = {hs, vs, de, (h == 0), (h == 0 && v == 0), (h == 0 && v == t.va),
                  16'(x), 16'(y)};
        end else begin
            e = m_prev[k];
            e[34:32] = 3'b000;
        end
        m_prev[k] = e;
        if (k == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [37:0] o, input logic [37:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // ---------------- driver ----------------
    // Drive one cycle on both instances, then pop and compare both queues
    task automatic step(input bit s0, input bit r0, input bit s1, input bit r1);
        logic [37:0] e;
        stb0 = s0; rst0 = r0; stb1 = s1; rst1 = r1;
        model(0, r0, s0);
        model(1, r1, s1);
        @(posedge clk);
        #1;
        if (exp_q0.size() == 0) chk("q0_empty", 38'd1, 38'd0);
        else begin e = exp_q0.pop_front(); chk("sb_dut0", obs0, e); end
        if (exp_q1.size() == 0) chk("q1_empty", 38'd1, 38'd0);
        else begin e = exp_q1.pop_front(); chk("sb_dut1", obs1, e); end
    endtask

    // Small-instance tracking: own line index, frame / vblank spacing
    int n_stb, last_fs, n_fs, p_h, bad_gap, bad_hs;

    task automatic small_cycle(input bit s);
        step(1'b0, 1'b0, s, 1'b0);
        if (!s) begin
            if (o_ls1 || o_fs1 || o_vbs1) bad_gap++;
        end else begin
            n_stb++;
            p_h = (p_h + 1) % 8;
            if (o_hs1 !== (p_h == 5 || p_h == 6)) bad_hs++;
            if (o_ls1 !== (p_h == 0)) bad_hs++;
            if (o_fs1) begin
                if (last_fs >= 0) chk("frame_gap", 38'(n_stb - last_fs), 38'd48);
                last_fs = n_stb;
                n_fs++;
            end
            if (o_vbs1 && last_fs >= 0) chk("vblank_gap", 38'(n_stb - last_fs), 38'd24);
        end
    endtask

    // ---------------- directed sequence ----------------
    int hs_lo, first_hs, last_hs, de_n, ls_n, fs_n, x639, x700;
    bit reached;

    initial begin
        tests = 0; fails = 0;
        rst0 = 1'b0; stb0 = 1'b0; rst1 = 1'b0; stb1 = 1'b0;
        m_prev[0] = '0; m_prev[1] = '0;
        @(posedge clk);
        #1;

        // Reset both instances
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("rst_vec0", obs0, {1'b1, 1'b1, 4'b0000, 32'd0});
        chk("rst_vec1", obs1, {1'b0, 1'b0, 4'b0000, 32'd0});

        // One full default line at full strobe rate
        hs_lo = 0; first_hs = -1; last_hs = -1; de_n = 0; ls_n = 0; fs_n = 0;
        x639 = 0; x700 = 0;
        for (int i = 0; i < 800; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            if (i == 0) chk("first_px", obs0, {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0});
            if (!o_hs0) begin
                hs_lo++;
                if (first_hs < 0) first_hs = i;
                last_hs = i;
            end
            if (o_de0) de_n++;
            if (o_ls0) ls_n++;
            if (o_fs0) fs_n++;
            if (i == 639) x639 = int'(o_x0);
            if (i == 700) x700 = int'(o_x0);
        end
        chk("hs_width", 38'(hs_lo), 38'd96);
        chk("hs_first", 38'(first_hs), 38'd656);
        chk("hs_last", 38'(last_hs), 38'd751);
        chk("de_count", 38'(de_n), 38'd640);
        chk("line_pulses", 38'(ls_n), 38'd1);
        chk("frame_pulses", 38'(fs_n), 38'd1);
        chk("x_end", 38'(x639), 38'd639);
        chk("x_sat", 38'(x700), 38'd639);

        // Second line begins: line strobe only, y advances
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("line2_start", obs0, {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 16'd1});

        // Walk to (300,1), then reset together with a strobe
        reached = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (m_h[0] == 300 && m_v[0] == 1) begin
                reached = 1'b1;
                break;
            end
            step(1'b1, 1'b0, 1'b0, 1'b0);
        end
        chk("reach_300_1", 38'(reached), 38'd1);
        chk("pos_300_1", obs0, {1'b1, 1'b1, 1'b1, 3'b000, 16'd300, 16'd1});
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("mid_rst0", obs0, {1'b1, 1'b1, 4'b0000, 32'd0});
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_hold0", obs0, {1'b1, 1'b1, 4'b0000, 32'd0});
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("restart0", obs0, {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0});

        // Tiny instance with random strobe gaps (still parked since reset)
        n_stb = 0; last_fs = -1; n_fs = 0; p_h = 7; bad_gap = 0; bad_hs = 0;
        for (int i = 0; i < 600; i++) begin
            small_cycle($urandom_range(0, 2) != 0);
        end
        chk("gap_strobes", 38'(bad_gap), 38'd0);
        chk("hs_region", 38'(bad_hs), 38'd0);
        chk("frames_seen", 38'(n_fs >= 5), 38'd1);

        // Tiny instance: mid-frame reset with strobe, then full-rate frames
        small_cycle(1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        chk("mid_rst1", obs1, {1'b0, 1'b0, 4'b0000, 32'd0});
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("restart1", obs1, {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0});
        n_stb = 1; last_fs = 1; n_fs = 1; p_h = 0;
        for (int i = 0; i < 150; i++) begin
            small_cycle(1'b1);
        end
        chk("full_rate_frames", 38'(n_fs), 38'd4);
        chk("hs_region_full", 38'(bad_hs), 38'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
